vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters SHALL be: H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48, V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, giving H total 800 and V total 525.
REQ-002 iVGA_CLK  in  1  pixel clock; the block SHALL have exactly one clock.
REQ-003 iRST_n  in  1  reset; it SHALL be asynchronous and active-low.
REQ-004 oVGA_X  out  10  pixel column sent to the pattern generator.
REQ-005 oVGA_Y  out  10  pixel row sent to the pattern generator.
REQ-006 iRed, iGreen, iBlue  in  10 each  colour returned by the pattern generator, registered one cycle after X/Y.
REQ-007 oVGA_R, oVGA_G, oVGA_B  out  10 each  colour driven to the DAC.
REQ-008 oVGA_HS, oVGA_VS  out  1 each  syncs, active-low.
REQ-009 oVGA_BLANK_n  out  1  high while a visible pixel is on the output.
REQ-010 oFrame_start  out  1  one-cycle pulse per frame, used by game logic to step the ball and slider.

Function
REQ-011 h_cnt SHALL count 0..799, incrementing every cycle and wrapping from 799 to 0.
REQ-012 v_cnt SHALL increment when h_cnt wraps, and SHALL wrap from 524 to 0 when both counters are at their maximum.
REQ-013 oVGA_X/oVGA_Y SHALL be registered and equal h_cnt/v_cnt inside the visible area (h_cnt<640 and v_cnt<480); each SHALL be 0 when its own counter is outside its visible range.
REQ-014 Stage 1 SHALL register, from counter state T: visible = (h<640 && v<480), hs_n = !(656<=h<=751), vs_n = !(490<=v<=491).
REQ-015 Stage 2 SHALL register the stage-1 flags onto oVGA_HS/oVGA_VS/oVGA_BLANK_n, and SHALL register oVGA_R/G/B = stage-1 visible ? iRed/iGreen/iBlue : 0.
REQ-016 Colour and syncs for counter state T SHALL appear on the outputs together at T+2, which is the fixed pipeline latency.
REQ-017 oFrame_start SHALL be registered and high for exactly the one cycle in which the oVGA_X/Y outputs show (0,0) after a wrap; it SHALL be asserted once per 420000 cycles.
REQ-018 Input colour SHALL be sampled only while the delayed visible flag is high; input during blanking SHALL be ignored.
REQ-019 All comparisons SHALL be unsigned on the 10-bit counters, with no wider intermediates required.

Reset
REQ-020 When iRST_n is low, the block SHALL immediately (asynchronously) set: h_cnt=0, v_cnt=0, oVGA_X=0, oVGA_Y=0, oVGA_R/G/B=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_n=0, oFrame_start=0, and all pipeline flags to the inactive state.
REQ-021 A reset asserted mid-frame SHALL abort the frame.
REQ-022 On the first clock edge after deassertion, counting SHALL restart at (0,0), and oFrame_start SHALL NOT pulse for that partial start.
REQ-023 The first oFrame_start after reset SHALL occur at the first wrap from (799,524).

Configuration
REQ-024 Macro VGA_TIMING_BORDER_EN, when defined, SHALL force oVGA_R/G/B to 10'h3FF on visible pixels with X==0, X==639, Y==0 or Y==479, overriding the input colour; the override SHALL be aligned through the same 2-stage pipeline.
REQ-025 When VGA_TIMING_BORDER_EN is undefined, the block SHALL pass input colour unmodified and SHALL contain no border logic.

Verification
REQ-026 Release reset, run 1000 cycles -> first HS low pulse lasts exactly 96 cycles, and hs_n for h_cnt=656 appears on oVGA_HS at cycle 658.
REQ-027 Run 2 full frames -> oFrame_start pulses exactly once per 420000 cycles; VS is low for 1600 cycles per frame; BLANK_n is high for 307200 cycles per frame.
REQ-028 Drive iRed = registered(oVGA_X) -> on every cycle with BLANK_n high, oVGA_R equals the column of that pixel; 0 during blanking.
REQ-029 Drive iRed=iGreen=iBlue=10'h155 during blanking -> outputs remain 0.
REQ-030 Assert iRST_n low at h=300, v=200 for 3 cycles -> outputs take their reset values within the same cycle; after release, X=0,Y=0, and the next frame pulse occurs 420000 cycles later.
REQ-031 With VGA_TIMING_BORDER_EN defined and input 0 -> pixels (0,y), (639,y), (x,0), (x,479) output 3FF; pixel (320,240) outputs 0.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with a fixed two-stage output pipeline.
//
// Counter state T (h_cnt, v_cnt) produces:
//   - oVGA_X / oVGA_Y at T+1. These go to the pattern generator, which returns colour
//     on iRed / iGreen / iBlue in the cycle that X/Y are shown.
//   - oVGA_HS / oVGA_VS / oVGA_BLANK_n and oVGA_R/G/B together at T+2.
//   - oFrame_start: a one-cycle pulse while X/Y show (0,0) after a wrap from the last pixel.
//     It does not pulse for the partial frame that follows reset.
//
// Ports:
//   iVGA_CLK                     pixel clock (the only clock)
//   iRST_n                       asynchronous active-low reset
//   oVGA_X, oVGA_Y     [9:0]     pixel column/row; 0 outside the visible range
//   iRed, iGreen, iBlue [9:0]    colour from the pattern generator
//   oVGA_R, oVGA_G, oVGA_B [9:0] colour to the DAC; 0 during blanking
//   oVGA_HS, oVGA_VS             active-low syncs
//   oVGA_BLANK_n                 high while a visible pixel is on the output
//   oFrame_start                 one pulse per frame
//
// Optional feature: define VGA_TIMING_BORDER_EN to force colour 10'h3FF on the outermost
// visible rows and columns.
module vga_timing_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_n,
  output logic       oFrame_start
);

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_MAX      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_MAX      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_cnt_nxt, v_cnt_nxt;
  logic       h_last, v_last;
  logic       h_vis, v_vis;
  logic       hs_now_n, vs_now_n;

  // Set while the counters sit at (0,0) after a wrap; delays the frame pulse onto the
  // cycle where X/Y show (0,0).
  logic       wrap;

  // Stage-1 flags for the counter state of the previous cycle.
  logic       vis1, hs1_n, vs1_n;

  always_comb begin
    h_last    = (h_cnt == H_MAX);
    v_last    = (v_cnt == V_MAX);
    h_vis     = (h_cnt < H_VIS);
    v_vis     = (v_cnt < V_VIS);
    hs_now_n  = !((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END));
    vs_now_n  = !((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END));
    h_cnt_nxt = h_last ? 10'd0 : h_cnt + 10'd1;
    v_cnt_nxt = v_cnt;
    if (h_last) begin
      v_cnt_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      oVGA_X       <= '0;
      oVGA_Y       <= '0;
      wrap         <= 1'b0;
      oFrame_start <= 1'b0;
      vis1         <= 1'b0;
      hs1_n        <= 1'b1;
      vs1_n        <= 1'b1;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_n <= 1'b0;
    end else begin
      h_cnt        <= h_cnt_nxt;
      v_cnt        <= v_cnt_nxt;
      oVGA_X       <= h_vis ? h_cnt : 10'd0;
      oVGA_Y       <= v_vis ? v_cnt : 10'd0;
      wrap         <= h_last && v_last;
      oFrame_start <= wrap;
      vis1         <= h_vis && v_vis;
      hs1_n        <= hs_now_n;
      vs1_n        <= vs_now_n;
      oVGA_HS      <= hs1_n;
      oVGA_VS      <= vs1_n;
      oVGA_BLANK_n <= vis1;
    end
  end

`ifdef VGA_TIMING_BORDER_EN
  localparam logic [9:0] H_LAST_VIS = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_LAST_VIS = 10'(V_VISIBLE - 1);

  logic border1;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      border1 <= 1'b0;
      oVGA_R  <= '0;
      oVGA_G  <= '0;
      oVGA_B  <= '0;
    end else begin
      border1 <= h_vis && v_vis &&
                 ((h_cnt == 10'd0) || (h_cnt == H_LAST_VIS) ||
                  (v_cnt == 10'd0) || (v_cnt == V_LAST_VIS));
      if (vis1) begin
        oVGA_R <= border1 ? 10'h3FF : iRed;
        oVGA_G <= border1 ? 10'h3FF : iGreen;
        oVGA_B <= border1 ? 10'h3FF : iBlue;
      end else begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
      end
    end
  end
`else
  // Input colour is only sampled while the delayed visible flag is set.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVGA_R <= '0;
      oVGA_G <= '0;
      oVGA_B <= '0;
    end else begin
      oVGA_R <= vis1 ? iRed   : 10'd0;
      oVGA_G <= vis1 ? iGreen : 10'd0;
      oVGA_B <= vis1 ? iBlue  : 10'd0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: one full-size instance (sync timing near reset) and one
// reduced-geometry instance (frame wraps, frame pulses, per-frame counts, mid-frame reset),
// both checked every cycle against a time-indexed model of the raster.
module tb_vga_timing_ctrl;

  // Reduced geometry: 30 x 18 = 540 cycles per frame.
  localparam int SHV = 20, SHF = 2, SHS = 3, SHB = 5;
  localparam int SVV = 12, SVF = 1, SVS = 2, SVB = 3;

  typedef struct packed {
    logic [9:0] x, y, r, g, b;
    logic       hs, vs, blank, fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode = 0;
  int errors = 0;
  int checks = 0;
  int k = 0;
  int gcyc = 0;

  logic [9:0] b_x, b_y, b_ir, b_ig, b_ib, b_or, b_og, b_ob, b_rr, b_rg, b_rb;
  logic       b_hs, b_vs, b_blank, b_fs;
  logic [9:0] s_x, s_y, s_ir, s_ig, s_ib, s_or, s_og, s_ob, s_rr, s_rg, s_rb;
  logic       s_hs, s_vs, s_blank, s_fs;

  // Mode 0: red tracks the pixel column (pattern generator answering X).
  assign b_ir = (mode == 0) ? b_x : b_rr;
  assign b_ig = b_rg;
  assign b_ib = b_rb;
  assign s_ir = (mode == 0) ? s_x : s_rr;
  assign s_ig = s_rg;
  assign s_ib = s_rb;

  vga_timing_ctrl u_big (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(b_x), .oVGA_Y(b_y),
    .iRed(b_ir), .iGreen(b_ig), .iBlue(b_ib),
    .oVGA_R(b_or), .oVGA_G(b_og), .oVGA_B(b_ob),
    .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK_n(b_blank), .oFrame_start(b_fs)
  );

  vga_timing_ctrl #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(s_x), .oVGA_Y(s_y),
    .iRed(s_ir), .iGreen(s_ig), .iBlue(s_ib),
    .oVGA_R(s_or), .oVGA_G(s_og), .oVGA_B(s_ob),
    .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_BLANK_n(s_blank), .oFrame_start(s_fs)
  );

  // Clock edges since reset release; k=0 is the reset / first-after-release state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d (k=%0d): got %0h, expected %0h", name, gcyc, k, act, exp);
    end
  endtask

  // Expected outputs k clock edges after release. X/Y reflect raster position k-1;
  // syncs, blank and colour reflect position k-2; colour comes from the input of cycle k-1.
  function automatic obs_t model(input int kk, input int hv, input int hf, input int hs,
                                 input int hb, input int vv, input int vf, input int vs,
                                 input int vb, input logic [9:0] pr, input logic [9:0] pg,
                                 input logic [9:0] pb);
    obs_t e;
    int ht, ft, p, h, v;
    logic vis, border;
    ht = hv + hf + hs + hb;
    ft = ht * (vv + vf + vs + vb);
    e = '{x: 10'd0, y: 10'd0, r: 10'd0, g: 10'd0, b: 10'd0,
          hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0};
    if (kk >= 1) begin
      p = (kk - 1) % ft;
      h = p % ht;
      v = p / ht;
      e.x  = (h < hv) ? 10'(h) : 10'd0;
      e.y  = (v < vv) ? 10'(v) : 10'd0;
      e.fs = (kk > ft) && (p == 0);
    end
    if (kk >= 2) begin
      p = (kk - 2) % ft;
      h = p % ht;
      v = p / ht;
      vis = (h < hv) && (v < vv);
      e.hs = !((h >= hv + hf) && (h < hv + hf + hs));
      e.vs = !((v >= vv + vf) && (v < vv + vf + vs));
      e.blank = vis;
`ifdef VGA_TIMING_BORDER_EN
      border = (h == 0) || (h == hv - 1) || (v == 0) || (v == vv - 1);
`else
      border = 1'b0;
`endif
      if (vis) begin
        e.r = border ? 10'h3FF : pr;
        e.g = border ? 10'h3FF : pg;
        e.b = border ? 10'h3FF : pb;
      end
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".x"}, 32'(a.x), 32'(e.x));
    chk({tag, ".y"}, 32'(a.y), 32'(e.y));
    chk({tag, ".r"}, 32'(a.r), 32'(e.r));
    chk({tag, ".g"}, 32'(a.g), 32'(e.g));
    chk({tag, ".b"}, 32'(a.b), 32'(e.b));
    chk({tag, ".hs"}, 32'(a.hs), 32'(e.hs));
    chk({tag, ".vs"}, 32'(a.vs), 32'(e.vs));
    chk({tag, ".blank_n"}, 32'(a.blank), 32'(e.blank));
    chk({tag, ".frame_start"}, 32'(a.fs), 32'(e.fs));
  endtask

  logic [9:0] pb_r = '0, pb_g = '0, pb_b = '0, ps_r = '0, ps_g = '0, ps_b = '0;
  obs_t eb, es, ab, as_;
  int hs_len = 0, vs_low = 0, blank_hi = 0, last_fs = 0;
  bit seen_fs = 1'b0;

  always @(negedge clk) begin
    gcyc++;
    eb  = model(k, 640, 16, 96, 48, 480, 10, 2, 33, pb_r, pb_g, pb_b);
    es  = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, ps_r, ps_g, ps_b);
    ab  = '{x: b_x, y: b_y, r: b_or, g: b_og, b: b_ob,
            hs: b_hs, vs: b_vs, blank: b_blank, fs: b_fs};
    as_ = '{x: s_x, y: s_y, r: s_or, g: s_og, b: s_ob,
            hs: s_hs, vs: s_vs, blank: s_blank, fs: s_fs};
    cmp("big", ab, eb);
    cmp("small", as_, es);

    if (!rst_n) begin
      seen_fs  = 1'b0;
      hs_len   = 0;
      vs_low   = 0;
      blank_hi = 0;
    end else begin
      // Hand-computed pins on the full-size timing.
      if (k == 657) chk("hs_before_658", 32'(b_hs), 32'd1);
      if (k == 658) chk("hs_at_658", 32'(b_hs), 32'd0);
      if (k >= 1 && k <= 800 && !b_hs) hs_len++;
      if (k == 800) chk("hs_first_pulse_len", 32'(hs_len), 32'd96);
      if (k == 800) chk("big_no_frame_pulse_yet", 32'(b_fs), 32'd0);

      // Per-frame statistics on the reduced geometry.
      if (s_fs) begin
        if (!seen_fs) begin
          chk("fs_first_after_reset_k", 32'(k), 32'd541);
        end else begin
          chk("fs_spacing", 32'(gcyc - last_fs), 32'd540);
          chk("vs_low_per_frame", 32'(vs_low), 32'd60);
          chk("blank_hi_per_frame", 32'(blank_hi), 32'd240);
        end
        seen_fs  = 1'b1;
        last_fs  = gcyc;
        vs_low   = 0;
        blank_hi = 0;
      end
      if (!s_vs) vs_low++;
      if (s_blank) blank_hi++;
    end

    pb_r = b_ir; pb_g = b_ig; pb_b = b_ib;
    ps_r = s_ir; ps_g = s_ig; ps_b = s_ib;
  end

  task automatic chk_reset_now();
    chk("async_big_x", 32'(b_x), 32'd0);
    chk("async_big_y", 32'(b_y), 32'd0);
    chk("async_big_r", 32'(b_or), 32'd0);
    chk("async_big_hs", 32'(b_hs), 32'd1);
    chk("async_big_vs", 32'(b_vs), 32'd1);
    chk("async_big_blank_n", 32'(b_blank), 32'd0);
    chk("async_small_x", 32'(s_x), 32'd0);
    chk("async_small_g", 32'(s_og), 32'd0);
    chk("async_small_fs", 32'(s_fs), 32'd0);
  endtask

  initial begin
    b_rr = '0; b_rg = '0; b_rb = '0;
    s_rr = '0; s_rg = '0; s_rb = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3600; c++) begin
      @(posedge clk);
      #1;
      mode = (c / 100) % 3;
      if (mode == 2) begin
        // Blanking-time junk must never reach the DAC.
        b_rr = 10'h155; b_rg = 10'h155; b_rb = 10'h155;
        s_rr = 10'h155; s_rg = 10'h155; s_rb = 10'h155;
      end else begin
        b_rr = 10'($urandom); b_rg = 10'($urandom); b_rb = 10'($urandom);
        s_rr = 10'($urandom); s_rg = 10'($urandom); s_rb = 10'($urandom);
      end
      if (c == 2000) begin
        #1 rst_n = 1'b0;
        #1 chk_reset_now();
      end
      if (c == 2003) begin
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
